// File: rtl/karatsuba_seq_ctrl_pkg.sv
// rtl/karatsuba_seq_ctrl_pkg.sv - shared state encoding and width helpers for the Karatsuba scheduler
package karatsuba_seq_ctrl_pkg;

  localparam int N_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    MUL_HH,
    MUL_LL,
    MUL_MID,
    COMBINE,
    DONE
  } state_t;

  // Shared multiplier operand width: half width plus the carry of AH+AL.
  function automatic int op_w(input int k);
    return k + 1;
  endfunction

  function automatic int mid_w(input int k);
    return 2 * k + 2;
  endfunction

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/kara_mul_shared.sv
// rtl/kara_mul_shared.sv - combinational unsigned WxW multiplier shared by all partial products
module kara_mul_shared
  import karatsuba_seq_ctrl_pkg::*;
#(
  parameter int W = op_w(N_DEF / 2)
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] prod
);

  assign prod = x * y;

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// rtl/karatsuba_seq_ctrl.sv - sequential Karatsuba scheduler, one shared multiplier for HH, LL and mid
module karatsuba_seq_ctrl
  import karatsuba_seq_ctrl_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int K         = N / 2,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int KW = op_w(K);
  localparam int MW = mid_w(K);
  localparam int PW = prod_w(N);

  state_t        state;
  logic [K-1:0]  ah, al, bh, bl;
  logic [KW-1:0] s1, s2;
  logic [KW-1:0] mx, my;
  logic [2*K-1:0] m1, m2;
  logic [MW-1:0] m3;
  logic [MW-1:0] prod;
  logic [MW-1:0] mid;
  logic [PW-1:0] sum;
  logic          skip_hh;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign skip_hh  = EARLY_OUT && ((a[N-1:K] == '0) || (b[N-1:K] == '0));

  always_comb begin
    mx = s1;
    my = s2;
    case (state)
      MUL_HH: begin
        mx = {1'b0, ah};
        my = {1'b0, bh};
      end
      MUL_LL: begin
        mx = {1'b0, al};
        my = {1'b0, bl};
      end
      default: ;
    endcase
  end

  kara_mul_shared #(.W(KW)) u_mul (
    .x    (mx),
    .y    (my),
    .prod (prod)
  );

  // Bits above 2N of the full Karatsuba sum are always zero, so the sum is formed at 2N directly.
  assign mid = m3 - MW'(m1) - MW'(m2);
  assign sum = (PW'(m1) << N) + (PW'(mid) << K) + PW'(m2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ah        <= '0;
      al        <= '0;
      bh        <= '0;
      bl        <= '0;
      s1        <= '0;
      s2        <= '0;
      m1        <= '0;
      m2        <= '0;
      m3        <= '0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ah    <= a[N-1:K];
            al    <= a[K-1:0];
            bh    <= b[N-1:K];
            bl    <= b[K-1:0];
            s1    <= KW'(a[N-1:K]) + KW'(a[K-1:0]);
            s2    <= KW'(b[N-1:K]) + KW'(b[K-1:0]);
            m1    <= '0;
            state <= skip_hh ? MUL_LL : MUL_HH;
          end
        end
        MUL_HH: begin
          m1    <= prod[2*K-1:0];
          state <= MUL_LL;
        end
        MUL_LL: begin
          m2    <= prod[2*K-1:0];
          state <= MUL_MID;
        end
        MUL_MID: begin
          m3    <= prod;
          state <= COMBINE;
        end
        COMBINE: begin
          p         <= sum;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// tb/tb_karatsuba_seq_ctrl.sv - self-checking bench for karatsuba_seq_ctrl, early-out on and off
module tb_karatsuba_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready1, out_valid1, busy1;
  logic        in_ready0, out_valid0, busy0;
  logic [63:0] p1, p0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  karatsuba_seq_ctrl #(.N(32), .K(16), .EARLY_OUT(1'b1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .p         (p1),
    .busy      (busy1)
  );

  karatsuba_seq_ctrl #(.N(32), .K(16), .EARLY_OUT(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .a         (a),
    .b         (b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .p         (p0),
    .busy      (busy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready1 && in_ready0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_reached", {63'b0, in_ready1 && in_ready0}, 64'd1);
  endtask

  task automatic accept(input logic [31:0] aa, input logic [31:0] bb);
    logic [16:0] s1_want;
    s1_want = 17'(aa[31:16]) + 17'(aa[15:0]);
    @(negedge clk);
    a = aa;
    b = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_after_accept", {63'b0, busy1}, 64'd1);
    chk("s1_sum", {47'b0, dut1.s1}, {47'b0, s1_want});
  endtask

  task automatic do_op(input logic [31:0] aa, input logic [31:0] bb);
    logic [63:0] want;
    int          lat1;
    int          n;
    bit          g1, g0;
    want = {32'b0, aa} * {32'b0, bb};
    lat1 = (aa[31:16] == 16'd0 || bb[31:16] == 16'd0) ? 3 : 4;
    n = 0;
    g1 = 1'b0;
    g0 = 1'b0;
    wait_idle();
    out_ready = 1'b1;
    accept(aa, bb);
    while (!(g1 && g0) && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (!g1 && out_valid1) begin
        g1 = 1'b1;
        chk("latency_eo1", 64'(n), 64'(lat1));
        chk("product_eo1", p1, want);
      end
      if (!g0 && out_valid0) begin
        g0 = 1'b1;
        chk("latency_eo0", 64'(n), 64'd4);
        chk("product_eo0", p0, want);
      end
    end
    chk("results_seen", {62'b0, g1, g0}, 64'd3);
    @(posedge clk);
    #1;
    chk("consumed_idle", {60'b0, out_valid1, out_valid0, in_ready1, in_ready0}, 64'b0011);
  endtask

  initial begin
    logic [63:0] want;
    logic [31:0] ra, rb;
    int          n;
    bit          spurious;

    #12;
    chk("rst_out_valid", {63'b0, out_valid1}, 64'd0);
    chk("rst_p", p1, 64'd0);
    chk("rst_busy", {63'b0, busy1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {62'b0, in_ready1, in_ready0}, 64'd3);

    do_op(32'h0001_0001, 32'h0001_0001);
    chk("p_plan_1", p1, 64'h0000_0001_0002_0001);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("p_all_ones", p1, 64'hFFFF_FFFE_0000_0001);
    do_op(32'h0000_1234, 32'hFFFF_0000);
    chk("p_early_out", p0, 64'h0000_1233_EDCC_0000);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra[31:16] = 16'd0;
      if (i % 4 == 2) rb[31:16] = 16'd0;
      do_op(ra, rb);
    end

    // Backpressure with an ignored in_valid pulse while DONE.
    wait_idle();
    @(negedge clk);
    out_ready = 1'b0;
    want = 64'h0000_0000_DEAD_BEEF * 64'h0000_0000_1234_5678;
    accept(32'hDEAD_BEEF, 32'h1234_5678);
    n = 0;
    while (!out_valid1 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_rise", {63'b0, out_valid1}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      a = 32'h0000_0003;
      b = 32'h0000_0007;
      @(posedge clk);
      #1;
      chk("bp_p_stable", p1, want);
      chk("bp_p_stable0", p0, want);
      chk("bp_hold", {61'b0, out_valid1, in_ready1, in_ready0}, 64'b100);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {62'b0, out_valid1, out_valid0}, 64'd0);
    spurious = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid1 || out_valid0) spurious = 1'b1;
    end
    chk("bp_pulse_ignored", {63'b0, spurious}, 64'd0);

    // Asynchronous reset while in MUL_LL.
    accept(32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    #1;
    chk("pre_reset_busy", {63'b0, busy1}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid1}, 64'd0);
    chk("midrst_p", p1, 64'd0);
    chk("midrst_busy", {62'b0, busy1, busy0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid1 || out_valid0) spurious = 1'b1;
    end
    chk("midrst_no_output", {63'b0, spurious}, 64'd0);
    do_op(32'h0000_0000, 32'h0000_0005);
    chk("p_after_reset", p1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
